// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Control FSM for a stopwatch. It synchronizes and debounces the
//            start/pause, lap and clear push-buttons, turns each accepted
//            press into a one-cycle pulse, and sequences IDLE/RUN/PAUSE/LAP.
//            It also keeps a saturating lap counter.
// Ports    : counter_clk   - slow counter clock, rising edge
//            reset         - asynchronous, active-high
//            start_btn     - raw start/pause button
//            lap_btn       - raw lap button
//            clr_btn       - raw clear button
//            wrap          - one-cycle pulse when the time counter rolls over
//            count_en      - time counter advances when high
//            clear         - time counter held at zero when high
//            hold          - display frozen when high
//            state         - current FSM state code
//            lap_cnt       - laps taken, 0-9
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEB_LEN = 4
) (
  input  logic       counter_clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       lap_btn,
  input  logic       clr_btn,
  input  logic       wrap,
  output logic       count_en,
  output logic       clear,
  output logic       hold,
  output logic [1:0] state,
  output logic [3:0] lap_cnt
);

  // The counter only has to reach DEB_LEN-1; the DEB_LEN-th disagreeing
  // cycle toggles the level instead of incrementing.
  localparam int         CNT_W   = (DEB_LEN < 2) ? 1 : $clog2(DEB_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);
  localparam logic [3:0] LAP_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Button index: 0 = start, 1 = lap, 2 = clear
  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {clr_btn, lap_btn, start_btn};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;

    always_ff @(posedge counter_clk or posedge reset) begin
      if (reset) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        cnt     <= '0;
        level   <= 1'b0;
        level_d <= 1'b0;
      end else begin
        sync1   <= raw[b];
        sync2   <= sync1;
        level_d <= level;
        if (sync2 != level) begin
          if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    // Rising edge of the debounced level only; releases are silent.
    assign press[b] = level & ~level_d;
  end

  logic   start_p;
  logic   lap_p;
  logic   clr_p;
  state_t cur;
  state_t nxt;

  assign start_p = press[0];
  assign lap_p   = press[1];
  assign clr_p   = press[2];
  assign state   = cur;

  // Each state checks only the events it reacts to, in priority order
  // clr > wrap > start > lap, so an ignored higher-priority event never
  // masks a lower-priority one that does apply.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (start_p) nxt = RUN;
      end
      RUN: begin
        if (clr_p || wrap) nxt = IDLE;
        else if (start_p)  nxt = PAUSE;
        else if (lap_p)    nxt = LAP;
      end
      PAUSE: begin
        if (clr_p)        nxt = IDLE;
        else if (start_p) nxt = RUN;
      end
      LAP: begin
        if (clr_p || wrap) nxt = IDLE;
        else if (start_p)  nxt = PAUSE;
        else if (lap_p)    nxt = RUN;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered copies
  // always match the registered state code.
  always_ff @(posedge counter_clk or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      count_en <= 1'b0;
      clear    <= 1'b1;
      hold     <= 1'b0;
      lap_cnt  <= 4'd0;
    end else begin
      cur      <= nxt;
      count_en <= (nxt == RUN) || (nxt == LAP);
      clear    <= (nxt == IDLE);
      hold     <= (nxt == LAP);
      if (nxt == IDLE) begin
        lap_cnt <= 4'd0;
      end else if ((cur == RUN) && (nxt == LAP) && (lap_cnt != LAP_MAX)) begin
        lap_cnt <= lap_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Self-checking bench for stopwatch_ctrl: directed vector table,
//            hand-written corner sequences and randomized stimulus against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DEB_LEN = 4;

  logic       counter_clk;
  logic       reset;
  logic       start_btn;
  logic       lap_btn;
  logic       clr_btn;
  logic       wrap;
  logic       count_en;
  logic       clear;
  logic       hold;
  logic [1:0] state;
  logic [3:0] lap_cnt;

  stopwatch_ctrl #(.DEB_LEN(DEB_LEN)) dut (
    .counter_clk (counter_clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .lap_btn     (lap_btn),
    .clr_btn     (clr_btn),
    .wrap        (wrap),
    .count_en    (count_en),
    .clear       (clear),
    .hold        (hold),
    .state       (state),
    .lap_cnt     (lap_cnt)
  );

  initial counter_clk = 1'b0;
  always #5 counter_clk = ~counter_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: 0 start, 1 lap, 2 clear. Events: 0 clr, 1 wrap, 2 start, 3 lap.
  int trans [4][4];
  int m_s1 [3];
  int m_s2 [3];
  int m_cnt [3];
  int m_lvl [3];
  int m_prev [3];
  int m_state;
  int m_lap;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_lvl[i] = 0; m_prev[i] = 0;
    end
    m_state = 0;
    m_lap   = 0;
  endtask

  task automatic model_edge(input logic s, input logic l, input logic c, input logic w);
    int  ev [4];
    int  raw [3];
    int  nxt;
    bit  found;
    raw[0] = int'(s); raw[1] = int'(l); raw[2] = int'(c);
    ev[0] = (m_lvl[2] == 1 && m_prev[2] == 0) ? 1 : 0;
    ev[1] = int'(w);
    ev[2] = (m_lvl[0] == 1 && m_prev[0] == 0) ? 1 : 0;
    ev[3] = (m_lvl[1] == 1 && m_prev[1] == 0) ? 1 : 0;
    nxt   = m_state;
    found = 0;
    for (int e = 0; e < 4; e++) begin
      if (!found && ev[e] == 1 && trans[m_state][e] >= 0) begin
        nxt   = trans[m_state][e];
        found = 1;
      end
    end
    if (nxt == 0) m_lap = 0;
    else if (m_state == 1 && nxt == 3) m_lap = (m_lap < 9) ? m_lap + 1 : 9;
    m_state = nxt;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = m_lvl[i];
      if (m_s2[i] != m_lvl[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB_LEN) begin
          m_lvl[i] = m_s2[i];
          m_cnt[i] = 0;
        end
      end else begin
        m_cnt[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic [15:0] v;
    v = '0;
    v[8:7] = 2'(m_state);
    v[6:3] = 4'(m_lap);
    v[2]   = (m_state == 1 || m_state == 3);
    v[1]   = (m_state == 0);
    v[0]   = (m_state == 3);
    return v;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {7'd0, state, lap_cnt, count_en, clear, hold};
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic tick(input logic s, input logic l, input logic c, input logic w);
    start_btn = s; lap_btn = l; clr_btn = c; wrap = w;
    @(posedge counter_clk);
    model_edge(s, l, c, w);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic hold_btn(input int b, input int n);
    for (int k = 0; k < n; k++) tick(b == 0, b == 1, b == 2, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       s;
    logic       l;
    logic       c;
    logic       w;
    int         n;
    logic [1:0] st;
    logic [3:0] lc;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    trans = '{'{-1, -1, 1, -1},   // IDLE
              '{ 0,  0, 2,  3},   // RUN
              '{ 0, -1, 1, -1},   // PAUSE
              '{ 0,  0, 2,  1}};  // LAP

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6,  2'd0, 4'd0}; // press, not yet
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  2'd1, 4'd0}; // edge 7 -> RUN
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  2'd1, 4'd0}; // held: one pulse
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd1, 4'd0}; // release silent
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7,  2'd2, 4'd0}; // -> PAUSE
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd2, 4'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7,  2'd2, 4'd0}; // lap ignored
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  2'd2, 4'd0}; // wrap ignored
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd2, 4'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7,  2'd1, 4'd0}; // -> RUN
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd1, 4'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 7,  2'd3, 4'd1}; // -> LAP
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd3, 4'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  2'd0, 4'd0}; // wrap -> IDLE
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  2'd0, 4'd0}; // 3-cycle glitch
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd0, 4'd0};

    reset = 1'b1;
    start_btn = 1'b0; lap_btn = 1'b0; clr_btn = 1'b0; wrap = 1'b0;
    model_reset();
    #12;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_outs", {13'd0, count_en, clear, hold}, 16'b010);
    chk("rst_lap", 16'(lap_cnt), 16'd0);
    @(posedge counter_clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].s, tbl[i].l, tbl[i].c, tbl[i].w);
      chk($sformatf("vec%0d_state", i), 16'(state), 16'(tbl[i].st));
      chk($sformatf("vec%0d_lap", i), 16'(lap_cnt), 16'(tbl[i].lc));
    end

    // Lap alternation with saturation of the lap counter.
    hold_btn(0, 7);
    idle(10);
    chk("lapseq_run", 16'(state), 16'd1);
    for (int k = 1; k <= 21; k++) begin
      hold_btn(1, 7);
      if (k % 2 == 1) begin
        chk($sformatf("lap%0d_state", k), 16'(state), 16'd3);
        chk($sformatf("lap%0d_hold", k), 16'(hold), 16'd1);
        chk($sformatf("lap%0d_cnt", k), 16'(lap_cnt), 16'(((k + 1) / 2 > 9) ? 9 : (k + 1) / 2));
      end else begin
        chk($sformatf("lap%0d_state", k), 16'(state), 16'd1);
        chk($sformatf("lap%0d_hold", k), 16'(hold), 16'd0);
      end
      idle(10);
    end

    // Clear pulse and wrap together while in LAP.
    hold_btn(2, 6);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clrwrap_state", 16'(state), 16'd0);
    chk("clrwrap_lap", 16'(lap_cnt), 16'd0);
    chk("clrwrap_clear", 16'(clear), 16'd1);
    idle(10);

    // Wrap alone while running.
    hold_btn(0, 7);
    idle(10);
    chk("wrap_pre", 16'(state), 16'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_state", 16'(state), 16'd0);
    chk("wrap_ce", 16'(count_en), 16'd0);
    idle(2);

    // Reset between edges in PAUSE with start held through release.
    hold_btn(0, 7);
    idle(10);
    hold_btn(1, 7);
    idle(10);
    hold_btn(0, 7);
    idle(10);
    chk("pause_state", 16'(state), 16'd2);
    chk("pause_lap", 16'(lap_cnt), 16'd1);
    hold_btn(0, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_state", 16'(state), 16'd0);
    chk("async_outs", {13'd0, count_en, clear, hold}, 16'b010);
    chk("async_lap", 16'(lap_cnt), 16'd0);
    model_reset();
    #2 reset = 1'b0;
    hold_btn(0, 6);
    chk("rel_wait", 16'(state), 16'd0);
    hold_btn(0, 1);
    chk("rel_run", 16'(state), 16'd1);
    idle(10);

    // Randomized button activity against the model.
    begin
      int rem [3];
      logic lv [3];
      for (int i = 0; i < 3; i++) begin rem[i] = 0; lv[i] = 1'b0; end
      for (int cyc = 0; cyc < 3000; cyc++) begin
        for (int i = 0; i < 3; i++) begin
          if (rem[i] == 0) begin
            lv[i]  = ($urandom_range(0, 2) == 0);
            rem[i] = $urandom_range(1, 12);
          end
          rem[i]--;
        end
        tick(lv[0], lv[1], lv[2], ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
